// File: rtl/lcd_clk_tick_sequencer_if.sv
// rtl/lcd_clk_tick_sequencer_if.sv - delay timer handshake between LCD command sequencer and tick sequencer (dly_abort present under LCD_TICK_DLY_ABORT_EN)
interface lcd_clk_tick_sequencer_if #(
  parameter int DLY_W = 16
);
  logic             dly_start;
  logic [DLY_W-1:0] dly_us;
  logic             dly_busy;
  logic             dly_done;
`ifdef LCD_TICK_DLY_ABORT_EN
  logic             dly_abort;

  modport master (
    output dly_start,
    output dly_us,
    output dly_abort,
    input  dly_busy,
    input  dly_done
  );

  modport slave (
    input  dly_start,
    input  dly_us,
    input  dly_abort,
    output dly_busy,
    output dly_done
  );
`else
  modport master (
    output dly_start,
    output dly_us,
    input  dly_busy,
    input  dly_done
  );

  modport slave (
    input  dly_start,
    input  dly_us,
    output dly_busy,
    output dly_done
  );
`endif
endinterface

// File: rtl/lcd_clk_tick_sequencer.sv
// rtl/lcd_clk_tick_sequencer.sv - GLA0 reset synchronizer, ready hold, us/ms ticks and us delay timer (optional abort: LCD_TICK_DLY_ABORT_EN)
module lcd_clk_tick_sequencer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int HOLD_CYCLES = 1024,
  parameter int DLY_W       = 16
) (
  input  logic                     GLA0,
  input  logic                     M2F_RESET_N,
  output logic                     rst_sync_n,
  output logic                     ready,
  output logic                     tick_us,
  output logic                     tick_ms,
  lcd_clk_tick_sequencer_if.slave  dly
);

  localparam int US_DIV = CLK_FREQ_HZ / 1_000_000;
  localparam int PRE_W  = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(US_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [9:0]        MS_LAST   = 10'd999;
  localparam logic [DLY_W:0]    REM_ONE   = {{DLY_W{1'b0}}, 1'b1};

  if (US_DIV < 2 || (CLK_FREQ_HZ % 1_000_000) != 0) begin : g_bad_clk_freq
    $error("CLK_FREQ_HZ must be an integer multiple of 1 MHz and at least 2 MHz");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end

  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } top_state_e;

  typedef enum logic {
    DS_IDLE,
    DS_COUNT
  } dly_state_e;

  logic              sync1_q;
  logic              sync2_q;

  top_state_e        top_q,      top_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              ready_q,    ready_d;
  logic [PRE_W-1:0]  pre_cnt_q,  pre_cnt_d;
  logic [9:0]        ms_cnt_q,   ms_cnt_d;
  dly_state_e        dly_q,      dly_d;
  logic [DLY_W:0]    rem_q,      rem_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;

  logic              tick_us_w;
  logic              abort_w;

`ifdef LCD_TICK_DLY_ABORT_EN
  assign abort_w = dly.dly_abort;
`else
  assign abort_w = 1'b0;
`endif

  // Two-flop reset bridge: asserts with M2F_RESET_N, releases on the 2nd GLA0 edge.
  always_ff @(posedge GLA0 or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= 1'b1;
      sync2_q <= sync1_q;
    end
  end

  assign rst_sync_n = sync2_q;

  // Microsecond tick is live only once ready; it fires on the last prescaler count.
  assign tick_us_w = ready_q && (pre_cnt_q == PRE_LAST);

  // Next-state logic: HOLD/RUN sequencing, prescaler, ms counter and delay timer.
  always_comb begin
    top_d      = top_q;
    hold_cnt_d = hold_cnt_q;
    ready_d    = ready_q;
    pre_cnt_d  = pre_cnt_q;
    ms_cnt_d   = ms_cnt_q;
    dly_d      = dly_q;
    rem_d      = rem_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    // Hold counting starts on the first cycle the synchronized reset is released.
    case (top_q)
      ST_HOLD: begin
        if (rst_sync_n) begin
          if (hold_cnt_q == HOLD_LAST) begin
            ready_d = 1'b1;
            top_d   = ST_RUN;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        ready_d = 1'b1;
      end
      default: begin
        top_d = ST_HOLD;
      end
    endcase

    if (!ready_q) begin
      pre_cnt_d = '0;
    end else if (pre_cnt_q == PRE_LAST) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + 1'b1;
    end

    if (tick_us_w) begin
      ms_cnt_d = (ms_cnt_q == MS_LAST) ? 10'd0 : ms_cnt_q + 10'd1;
    end

    // Remaining is loaded with N+1 so the partial first microsecond never shortens the wait.
    case (dly_q)
      DS_IDLE: begin
        busy_d = 1'b0;
        if (ready_q && dly.dly_start) begin
          if (dly.dly_us == '0) begin
            done_d = 1'b1;
          end else begin
            rem_d  = {1'b0, dly.dly_us} + 1'b1;
            busy_d = 1'b1;
            dly_d  = DS_COUNT;
          end
        end
      end
      DS_COUNT: begin
        if (abort_w) begin
          rem_d  = '0;
          busy_d = 1'b0;
          dly_d  = DS_IDLE;
        end else if (tick_us_w) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == REM_ONE) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            dly_d  = DS_IDLE;
          end
        end
      end
      default: begin
        dly_d  = DS_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // State registers; an M2F_RESET_N assertion aborts everything and restarts the hold.
  always_ff @(posedge GLA0 or negedge M2F_RESET_N) begin
    if (!M2F_RESET_N) begin
      top_q      <= ST_HOLD;
      hold_cnt_q <= '0;
      ready_q    <= 1'b0;
      pre_cnt_q  <= '0;
      ms_cnt_q   <= '0;
      dly_q      <= DS_IDLE;
      rem_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      top_q      <= top_d;
      hold_cnt_q <= hold_cnt_d;
      ready_q    <= ready_d;
      pre_cnt_q  <= pre_cnt_d;
      ms_cnt_q   <= ms_cnt_d;
      dly_q      <= dly_d;
      rem_q      <= rem_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ready        = ready_q;
  assign tick_us      = tick_us_w;
  assign tick_ms      = tick_us_w && (ms_cnt_q == MS_LAST);
  assign dly.dly_busy = busy_q;
  assign dly.dly_done = done_q;

endmodule

// File: tb/tb_lcd_clk_tick_sequencer.sv
// tb/tb_lcd_clk_tick_sequencer.sv - self-checking bench for lcd_clk_tick_sequencer with a timeline model
module tb_lcd_clk_tick_sequencer;

  localparam int CLK_FREQ_HZ = 4_000_000;
  localparam int U           = 4;
  localparam int H           = 16;
  localparam int DW          = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic rst_sync_n;
  logic ready;
  logic tick_us;
  logic tick_ms;

  lcd_clk_tick_sequencer_if #(.DLY_W(DW)) dif ();

  lcd_clk_tick_sequencer #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .HOLD_CYCLES (H),
    .DLY_W       (DW)
  ) dut (
    .GLA0        (clk),
    .M2F_RESET_N (rst_n),
    .rst_sync_n  (rst_sync_n),
    .ready       (ready),
    .tick_us     (tick_us),
    .tick_ms     (tick_ms),
    .dly         (dif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  // Timeline model: reset release cycle fixes rst_sync_n, ready and tick positions;
  // an accepted delay fixes its busy window and done cycle by counting ticks.
  bit m_rst_low = 1'b1;
  int m_rel     = -1000;
  int dm_bs     = -1;
  int dm_be     = -2;
  int dm_done   = -1;
  int m_r, m_n, m_f, m_first;
  bit e_rs, e_rdy, e_tus, e_tms, e_busy, e_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_rst_low = 1'b1;
      dm_bs     = -1;
      dm_be     = -2;
      dm_done   = -1;
    end else if (m_rst_low) begin
      m_rst_low = 1'b0;
      m_rel     = cyc;
    end
    m_r    = m_rel + 2 + H;
    e_rs   = !m_rst_low && (cyc >= m_rel + 2);
    e_rdy  = !m_rst_low && (cyc >= m_r);
    e_tus  = e_rdy && (((cyc - m_r) % U) == U - 1);
    e_tms  = e_tus && ((((cyc - m_r) / U) % 1000) == 999);
    e_busy = (cyc >= dm_bs) && (cyc <= dm_be);
    e_done = (cyc == dm_done);
    chk("rst_sync_n", rst_sync_n, e_rs);
    chk("ready", ready, e_rdy);
    chk("tick_us", tick_us, e_tus);
    chk("tick_ms", tick_ms, e_tms);
    chk("dly_busy", dif.dly_busy, e_busy);
    chk("dly_done", dif.dly_done, e_done);
`ifdef LCD_TICK_DLY_ABORT_EN
    if (e_busy && dif.dly_abort) begin
      dm_be   = cyc;
      dm_done = -1;
    end
`endif
    if (e_rdy && !e_busy && dif.dly_start) begin
      m_n = int'(dif.dly_us);
      if (m_n == 0) begin
        dm_done = cyc + 1;
      end else begin
        m_first = m_r + U - 1;
        if (cyc < m_first) m_f = m_first;
        else m_f = m_first + ((cyc - m_first) / U + 1) * U;
        dm_bs   = cyc + 1;
        dm_be   = m_f + m_n * U;
        dm_done = dm_be + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig_sel(input int which);
    case (which)
      0:       return ready;
      1:       return tick_us;
      2:       return tick_ms;
      default: return dif.dly_done;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (sig_sel(which)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=none expected=event within %0d cycles", nm, budget);
    end
  endtask

  task automatic start(input int n);
    dif.dly_start = 1'b1;
    dif.dly_us    = DW'(n);
    step();
    dif.dly_start = 1'b0;
    dif.dly_us    = ~DW'(n);
  endtask

  // Runs one delay to completion; optionally injects a start (dly_us=5) while busy.
  task automatic run_delay(input string nm, input int n, input int inj_at,
                           output int blen, output int dcnt);
    bit fin = 1'b0;
    start(n);
    blen = 0;
    dcnt = 0;
    for (int i = 0; i < 1200; i++) begin
      dif.dly_start = (i == inj_at);
      if (i == inj_at) dif.dly_us = DW'(5);
      if (dif.dly_busy) blen++;
      if (dif.dly_done) dcnt++;
      if (!dif.dly_busy && (blen > 0 || n == 0)) begin
        fin = 1'b1;
        break;
      end
      step();
    end
    dif.dly_start = 1'b0;
    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL %s timeout actual=busy expected=idle within 1200 cycles", nm);
    end
    repeat (5) begin
      step();
      if (dif.dly_done) dcnt++;
    end
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=%0d cycles expected=finish earlier", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  int k0, k1, at, blen, dcnt, stray, m1, m2, nt;

  initial begin
    dif.dly_start = 1'b0;
    dif.dly_us    = '0;
`ifdef LCD_TICK_DLY_ABORT_EN
    dif.dly_abort = 1'b0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk("reset_ready", ready, 0);
    chk("reset_rst_sync_n", rst_sync_n, 0);
    rst_n = 1'b1;
    k0    = cyc;

    // start while ready=0 is ignored
    repeat (3) step();
    start(3);
    stray = 0;
    for (int i = 0; i < 40 && !ready; i++) begin
      if (dif.dly_busy || dif.dly_done) stray++;
      step();
    end
    chk("start_before_ready_ignored", stray, 0);
    chk("ready_latency", cyc - k0, 18);
    wait_for("first_tick_us", 1, 20, at);
    chk("first_tick_us_latency", at - k0, 21);

    run_delay("dly40", 40, -1, blen, dcnt);
    chk("dly40_busy_in_range", (blen >= 161 && blen <= 164), 1);
    chk("dly40_one_done", dcnt, 1);

    start(0);
    chk("dly0_done_next", dif.dly_done, 1);
    chk("dly0_not_busy", dif.dly_busy, 0);
    repeat (4) step();

    run_delay("dly10_ignore", 10, 10, blen, dcnt);
    chk("dly10_busy_in_range", (blen >= 41 && blen <= 44), 1);
    chk("dly10_one_done", dcnt, 1);

    // start in the done cycle is accepted
    start(2);
    wait_for("dly2_done", 3, 30, at);
    start(3);
    chk("restart_on_done_busy", dif.dly_busy, 1);
    wait_for("dly3_done", 3, 30, at);
    repeat (3) step();

    run_delay("dly_max", 255, -1, blen, dcnt);
    chk("dlymax_busy_in_range", (blen >= 1021 && blen <= 1024), 1);
    chk("dlymax_one_done", dcnt, 1);

    wait_for("tick_ms_1", 2, 10000, m1);
    chk("first_tick_ms_latency", m1 - k0, 4017);
    nt = 0;
    m2 = -1;
    for (int i = 0; i < 4100; i++) begin
      step();
      if (tick_us) nt++;
      if (tick_ms) begin
        m2 = cyc;
        break;
      end
    end
    chk("tick_ms_period", m2 - m1, 4000);
    chk("tick_us_per_ms", nt, 1000);

    // reset 50 us into a 100 us delay
    start(100);
    repeat (200) step();
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", dif.dly_busy, 0);
    chk("midreset_ready", ready, 0);
    chk("midreset_rst_sync_n", rst_sync_n, 0);
    repeat (3) step();
    rst_n = 1'b1;
    k1    = cyc;
    stray = 0;
    for (int i = 0; i < 40 && !ready; i++) begin
      step();
      if (dif.dly_done) stray++;
    end
    chk("midreset_ready_latency", cyc - k1, 18);
    repeat (420) begin
      step();
      if (dif.dly_done) stray++;
    end
    chk("midreset_no_done", stray, 0);

`ifdef LCD_TICK_DLY_ABORT_EN
    start(10);
    repeat (11) step();
    dif.dly_abort = 1'b1;
    step();
    dif.dly_abort = 1'b0;
    chk("abort_busy_low", dif.dly_busy, 0);
    dcnt = 0;
    repeat (60) begin
      step();
      if (dif.dly_done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    start(10);
    for (int i = 0; i < 100 && cyc < dm_be; i++) step();
    dif.dly_abort = 1'b1;
    step();
    dif.dly_abort = 1'b0;
    dcnt = 0;
    repeat (10) begin
      if (dif.dly_done) dcnt++;
      step();
    end
    chk("abort_final_tick_no_done", dcnt, 0);

    dif.dly_abort = 1'b1;
    start(2);
    dif.dly_abort = 1'b0;
    chk("idle_abort_start_accepted", dif.dly_busy, 1);
    wait_for("idle_abort_done", 3, 30, at);
    repeat (3) step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
